// File: rtl/tap_delay_line.sv
// Multi-channel circular-buffer tap delay line: each accepted sample strobe streams every tap
// of every channel, newest first. Define TAP_DELAY_LINE_SYMMETRIC_FOLD_EN for folded readout.
module tap_delay_line #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 64,
  parameter int CHANNELS = 2
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              i_sample_valid,
  input  logic [CHANNELS*DATA_W-1:0]                        i_sample,
  output logic                                              o_ready,
  output logic signed [DATA_W:0]                            o_tap,
  output logic                                              o_tap_valid,
  output logic [$clog2(DEPTH)-1:0]                          o_tap_idx,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] o_chan,
  output logic                                              o_first,
  output logic                                              o_last,
  output logic                                              o_frame_done,
  output logic                                              o_overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int WW = CHANNELS * DATA_W;
`ifdef TAP_DELAY_LINE_SYMMETRIC_FOLD_EN
  localparam int TAPS = DEPTH / 2;
`else
  localparam int TAPS = DEPTH;
`endif

  typedef enum logic [1:0] {CLEAR, IDLE, READ} state_t;
  state_t state_q, state_d;

  logic [WW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, base, rd_k, addr_a;
  logic [CW-1:0] rd_ch;
  logic          last_addr, accept;

  assign last_addr = (rd_k == AW'(TAPS - 1)) && (rd_ch == CW'(CHANNELS - 1));
  assign accept    = i_sample_valid && o_ready;
  assign addr_a    = base - rd_k;

  always_ff @(posedge clk) begin
    if (rst) state_q <= CLEAR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    unique case (state_q)
      CLEAR: if (wr_ptr == AW'(DEPTH - 1)) state_d = IDLE;
      IDLE: begin
        o_ready = 1'b1;
        if (i_sample_valid) state_d = READ;
      end
      // The final read address overlaps the next write slot; the next frame may start here.
      READ: if (last_addr) begin
        o_ready = 1'b1;
        state_d = i_sample_valid ? READ : IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  // wr_ptr doubles as the CLEAR sweep address and wraps back to 0 when the sweep ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      base      <= '0;
      rd_k      <= '0;
      rd_ch     <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (state_q == CLEAR) begin
        wr_ptr <= wr_ptr + 1'b1;
      end else if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        base   <= wr_ptr;
        rd_k   <= '0;
        rd_ch  <= '0;
      end else if (state_q == READ) begin
        if (rd_k == AW'(TAPS - 1)) begin
          rd_k  <= '0;
          rd_ch <= rd_ch + 1'b1;
        end else begin
          rd_k <= rd_k + 1'b1;
        end
      end
      if (i_sample_valid && !o_ready) o_overrun <= 1'b1;
    end
  end

  // NOTE: the buffer and read words carry no reset so they can map onto RAM; CLEAR zeroes the taps.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem[wr_ptr] <= '0;
    else if (accept)      mem[wr_ptr] <= i_sample;
  end

  logic [WW-1:0] word_a;
  always_ff @(posedge clk) word_a <= mem[addr_a];

  logic                 s1_valid, s1_end;
  logic [AW-1:0]        s1_k;
  logic [CW-1:0]        s1_ch;
  logic signed [DATA_W-1:0] xa;
  logic signed [DATA_W:0]   tap_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_end   <= 1'b0;
      s1_k     <= '0;
      s1_ch    <= '0;
    end else begin
      s1_valid <= (state_q == READ);
      s1_end   <= (state_q == READ) && last_addr;
      s1_k     <= rd_k;
      s1_ch    <= rd_ch;
    end
  end

  assign xa = word_a[s1_ch*DATA_W +: DATA_W];

`ifdef TAP_DELAY_LINE_SYMMETRIC_FOLD_EN
  logic [AW-1:0]            addr_b;
  logic [WW-1:0]            word_b;
  logic signed [DATA_W-1:0] xb;

  // Mirror tap DEPTH-1-k lives at base - (DEPTH-1-k) = base + 1 + k.
  assign addr_b = base + AW'(1) + rd_k;
  always_ff @(posedge clk) word_b <= mem[addr_b];
  assign xb    = word_b[s1_ch*DATA_W +: DATA_W];
  assign tap_d = {xa[DATA_W-1], xa} + {xb[DATA_W-1], xb};
`else
  assign tap_d = {xa[DATA_W-1], xa};
`endif

  logic frame_end_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_tap_valid  <= 1'b0;
      o_tap        <= '0;
      o_tap_idx    <= '0;
      o_chan       <= '0;
      o_first      <= 1'b0;
      o_last       <= 1'b0;
      frame_end_q  <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_tap_valid  <= s1_valid;
      o_tap        <= s1_valid ? tap_d : '0;
      o_tap_idx    <= s1_valid ? s1_k : '0;
      o_chan       <= s1_valid ? s1_ch : '0;
      o_first      <= s1_valid && (s1_k == '0);
      o_last       <= s1_valid && (s1_k == AW'(TAPS - 1));
      frame_end_q  <= s1_end;
      o_frame_done <= frame_end_q;
    end
  end

endmodule

// File: tb/tb_tap_delay_line.sv
// Directed bench for tap_delay_line: a DEPTH=8/CHANNELS=2 instance plus a DEPTH=64/CHANNELS=1
// instance, checked against a shift-register history model (fold-aware).
module tb_tap_delay_line;
  localparam int DW = 16;
  localparam int D  = 8;
  localparam int C  = 2;
  localparam int D2 = 64;
`ifdef TAP_DELAY_LINE_SYMMETRIC_FOLD_EN
  localparam bit FOLD = 1'b1;
`else
  localparam bit FOLD = 1'b0;
`endif
  localparam int TAPS    = FOLD ? D / 2 : D;
  localparam int FR      = C * TAPS;
  localparam int TAPS2   = FOLD ? D2 / 2 : D2;
  localparam int RST_IDX = (TAPS > 5) ? 5 : TAPS - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, sv, ready, tv, first, last, fdone, ovr;
  logic [C*DW-1:0]      smp;
  logic signed [DW:0]   tap;
  logic [2:0]           idx;
  logic [0:0]           chan;

  logic                 rst_b, sv_b, ready_b, tv_b, first_b, last_b, fdone_b, ovr_b;
  logic [DW-1:0]        smp_b;
  logic signed [DW:0]   tap_b;
  logic [5:0]           idx_b;
  logic [0:0]           chan_b;

  tap_delay_line #(.DATA_W(DW), .DEPTH(D), .CHANNELS(C)) u_dut (
    .clk(clk), .rst(rst), .i_sample_valid(sv), .i_sample(smp), .o_ready(ready),
    .o_tap(tap), .o_tap_valid(tv), .o_tap_idx(idx), .o_chan(chan), .o_first(first),
    .o_last(last), .o_frame_done(fdone), .o_overrun(ovr)
  );

  tap_delay_line #(.DATA_W(DW), .DEPTH(D2), .CHANNELS(1)) u_dut64 (
    .clk(clk), .rst(rst_b), .i_sample_valid(sv_b), .i_sample(smp_b), .o_ready(ready_b),
    .o_tap(tap_b), .o_tap_valid(tv_b), .o_tap_idx(idx_b), .o_chan(chan_b), .o_first(first_b),
    .o_last(last_b), .o_frame_done(fdone_b), .o_overrun(ovr_b)
  );

  int errors = 0;
  int checks = 0;
  int hist_a [C][D];
  int hist_b [D2];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_a(input int ch, input int k);
    return FOLD ? hist_a[ch][k] + hist_a[ch][D-1-k] : hist_a[ch][k];
  endfunction

  function automatic int exp_b(input int k);
    return FOLD ? hist_b[k] + hist_b[D2-1-k] : hist_b[k];
  endfunction

  task automatic push_a(input int s0, input int s1);
    for (int k = D - 1; k > 0; k--) begin
      hist_a[0][k] = hist_a[0][k-1];
      hist_a[1][k] = hist_a[1][k-1];
    end
    hist_a[0][0] = s0;
    hist_a[1][0] = s1;
  endtask

  task automatic do_reset(input bit strobe_first);
    int   lowc;
    logic act;
    rst = 1'b1;
    sv  = 1'b0;
    step();
    check("rst_tap", tap, 0);
    check("rst_flags", {tv, first, last, fdone, ovr, ready}, 0);
    check("rst_tags", {idx, chan}, 0);
    step();
    rst  = 1'b0;
    sv   = strobe_first;
    smp  = {DW'(-1), DW'(99)};
    lowc = 0;
    act  = 1'b0;
    while (!ready && lowc < 4 * D) begin
      lowc++;
      act = act | tv | fdone;
      step();
      sv = 1'b0;
    end
    check("clear_len", lowc, D);
    check("clear_quiet", act, 0);
    for (int c = 0; c < C; c++)
      for (int k = 0; k < D; k++) hist_a[c][k] = 0;
  endtask

  task automatic strobe_a(input int s0, input int s1);
    int w = 0;
    while (!ready && w < 4 * FR) begin
      step();
      w++;
    end
    check("strobe_ready", ready, 1);
    smp = {DW'(s1), DW'(s0)};
    sv  = 1'b1;
    step();
    sv  = 1'b0;
    push_a(s0, s1);
  endtask

  task automatic check_frame_a(input string tag);
    int lat = 0;
    while (!tv && lat < 10) begin
      step();
      lat++;
    end
    check($sformatf("%s latency", tag), lat, 2);
    for (int n = 0; n < FR; n++) begin
      int ch;
      int k;
      ch = n / TAPS;
      k  = n % TAPS;
      check($sformatf("%s tap c%0d k%0d", tag, ch, k), tap, exp_a(ch, k));
      check($sformatf("%s flags c%0d k%0d", tag, ch, k), {tv, first, last, fdone},
            {1'b1, k == 0, k == TAPS - 1, 1'b0});
      check($sformatf("%s chan_idx c%0d k%0d", tag, ch, k), {chan, idx}, ch * D + k);
      step();
    end
    check($sformatf("%s frame_done", tag), {tv, fdone}, 2'b01);
  endtask

  initial begin
    rst   = 1'b1; sv   = 1'b0; smp   = '0;
    rst_b = 1'b1; sv_b = 1'b0; smp_b = '0;

    // Strobe in the first CLEAR cycle is dropped; then a clean single frame.
    do_reset(1'b1);
    check("t1 ovr_dropped", ovr, 1);
    do_reset(1'b0);
    check("t1 ovr_cleared", ovr, 0);
    strobe_a(5, -3);
    check_frame_a("t1");

    // Ten frames to wrap the write pointer.
    for (int i = 1; i <= 10; i++) begin
      strobe_a(i, -100 * i);
      check_frame_a($sformatf("t2 f%0d", i));
    end

    // Back-to-back frames at the minimum strobe period.
    strobe_a(11, -11);
    repeat (FR - 1) step();
    strobe_a(12, -12);
    check("t3 b2b tv_start", tv, 1);
    for (int i = 1; i <= FR + 2; i++) begin
      step();
      check($sformatf("t3 b2b tv i%0d", i), tv, (i <= FR + 1) ? 1 : 0);
      if (i == 2) begin
        check("t3 b2b done_overlap", {fdone, first, chan}, 3'b110);
        check("t3 b2b first_tap", tap, exp_a(0, 0));
      end
      if (i == FR + 2) check("t3 b2b done_end", fdone, 1);
    end
    check("t3 b2b no_ovr", ovr, 0);

    // One cycle too early: dropped, overrun sticks, later frames unaffected.
    strobe_a(13, -13);
    repeat (FR - 2) step();
    check("t3 early_ready", ready, 0);
    smp = {DW'(-77), DW'(77)};
    sv  = 1'b1;
    step();
    sv  = 1'b0;
    check("t3 ovr_set", ovr, 1);
    repeat (FR + 4) step();
    check("t3 ovr_sticky", ovr, 1);
    strobe_a(14, -14);
    check_frame_a("t3 after_drop");
    check("t3 ovr_still", ovr, 1);

    // Reset in the middle of channel 1's readout.
    strobe_a(21, 22);
    begin
      int w = 0;
      while (!(tv && chan == 1'b1 && idx == 3'(RST_IDX)) && w < 40) begin
        step();
        w++;
      end
      check("t4 reached_tap", tv && chan == 1'b1 && idx == 3'(RST_IDX), 1);
    end
    do_reset(1'b0);
    strobe_a(31, 32);
    check_frame_a("t4 post_reset");

    // Extreme values: fold sum must not overflow the DATA_W+1 output.
    for (int i = 0; i < D; i++) begin
      strobe_a(-32768, 32767);
      check_frame_a($sformatf("t5 f%0d", i));
    end

    // Single-channel, 64-deep instance against a history scoreboard.
    repeat (2) step();
    rst_b = 1'b0;
    for (int f = 0; f < 200; f++) begin
      int v;
      int w;
      v = int'($urandom_range(200, 1));
      w = 0;
      while (!ready_b && w < 300) begin
        step();
        w++;
      end
      check($sformatf("t6 f%0d ready", f), ready_b, 1);
      smp_b = DW'(v);
      sv_b  = 1'b1;
      step();
      sv_b  = 1'b0;
      for (int k = D2 - 1; k > 0; k--) hist_b[k] = hist_b[k-1];
      hist_b[0] = v;
      w = 0;
      while (!tv_b && w < 10) begin
        step();
        w++;
      end
      check($sformatf("t6 f%0d latency", f), w, 2);
      for (int k = 0; k < TAPS2; k++) begin
        check($sformatf("t6 f%0d tap k%0d", f, k), tap_b, exp_b(k));
        check($sformatf("t6 f%0d tags k%0d", f, k), {tv_b, first_b, last_b, chan_b, idx_b},
              {1'b1, k == 0, k == TAPS2 - 1, 1'b0, 6'(k)});
        step();
      end
      check($sformatf("t6 f%0d done", f), {tv_b, fdone_b}, 2'b01);
    end
    check("t6 no_ovr", ovr_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
